// File: rtl/led_bit_serializer_pkg.sv
// Shared definitions for the LED bit serializer: state encoding, counter-width
// helper and default timing for the 10 kHz LFOSC clock.
package led_show_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  // 125 ms per bit and a 250 ms blank between frames at 10 kHz
  localparam int DEFAULT_DWELL = 1250;
  localparam int DEFAULT_GAP   = 2500;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_bit_serializer_negate_n.sv
// Combinational WIDTH-bit two's complement negation with a flag for the
// most-negative input, whose negation wraps back onto itself.
module negate_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] neg,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  assign neg = ~value + WIDTH'(1);
  assign ovf = (value == MOST_NEG);

endmodule

// File: rtl/led_bit_serializer.sv
// Captures a word (optionally negated) and blinks it out one bit at a time on
// a single LED. Define LED_BIT_SERIALIZER_MSB_FIRST_EN to show MSB first.
module led_bit_serializer
  import led_show_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DWELL = DEFAULT_DWELL,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     negate,
  output logic                     busy,
  output logic                     done,
  output logic                     led,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     ovf
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int DW_W  = cnt_width(DWELL);
  localparam int GP_W  = cnt_width(GAP);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [GP_W-1:0] GAP_LAST   = GP_W'((GAP > 0) ? GAP - 1 : 0);

`ifdef LED_BIT_SERIALIZER_MSB_FIRST_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
`endif

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] neg_val;
  logic [WIDTH-1:0] capture_val;
  logic             neg_ovf;
  logic [IDX_W-1:0] next_idx;
  logic [DW_W-1:0]  dwell_cnt;
  logic [GP_W-1:0]  gap_cnt;

  negate_n #(
    .WIDTH(WIDTH)
  ) u_negate (
    .value(data_in),
    .neg  (neg_val),
    .ovf  (neg_ovf)
  );

  assign capture_val = negate ? neg_val : data_in;

`ifdef LED_BIT_SERIALIZER_MSB_FIRST_EN
  assign next_idx = bit_idx - IDX_W'(1);
`else
  assign next_idx = bit_idx + IDX_W'(1);
`endif

  // led is loaded together with bit_idx so the first bit is visible the
  // cycle right after the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_idx   <= '0;
      ovf       <= 1'b0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= capture_val;
            ovf       <= negate & neg_ovf;
            bit_idx   <= FIRST_IDX;
            led       <= capture_val[FIRST_IDX];
            dwell_cnt <= '0;
            busy      <= 1'b1;
            state     <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              led     <= 1'b0;
              gap_cnt <= '0;
              if (GAP == 0) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              bit_idx <= next_idx;
              led     <= shift_reg[next_idx];
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_bit_serializer.md
Name: led_bit_serializer

Overview:
Parametrised successor to the fixed 32-bit negate-and-blink display path. It captures a WIDTH-bit word and optionally two's-complement negates it. It then presents the word one bit at a time on a single LED output, holding each bit for DWELL clock cycles. It sits between arithmetic blocks and board LEDs on the iCE40, driven by the 10 kHz LFOSC clock, and uses a start/busy/done handshake so results can be shown back-to-back.

Parameters:
WIDTH, 32, bits in displayed word (>=2)
DWELL, 1250, clock cycles each bit is held on led (>=1)
GAP, 2500, cycles led is forced low between frames (>=0; 0 = no gap)

Ports:
clk  input  1  system clock (LFOSC, 10 kHz nominal)
rst  input  1  synchronous, active-high reset
start  input  1  request to capture data_in; honoured only when busy=0
data_in  input  WIDTH  word to display
negate  input  1  sampled with start; 1 = display two's complement of data_in
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last bit's dwell and the gap complete
led  output  1  current displayed bit
bit_idx  output  $clog2(WIDTH)  index of the bit currently on led
ovf  output  1  set on capture when negate=1 and data_in = 1 followed by zeros (most-negative value); held until next capture

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; led=0, busy=0, done=0, bit_idx=0, ovf=0; dwell counter and shift register cleared. Reset overrides everything, including a frame in progress; no done pulse is emitted.
- States: IDLE -> SHOW -> GAP -> IDLE. If GAP=0, SHOW goes directly to IDLE.
- IDLE: led=0. When start=1, on that edge:
  - shift_reg <= negate ? (~data_in + 1) mod 2^WIDTH : data_in
  - ovf <= negate & (data_in == {1'b1, zeros})
  - bit_idx <= 0, busy <= 1, state <= SHOW
- SHOW:
  - led = shift_reg[bit_idx], registered, so led follows bit_idx with 0 extra latency from the state register.
  - LSB first by default.
  - Dwell counter counts 0..DWELL-1; on reaching DWELL-1, bit_idx increments.
  - After bit WIDTH-1 completes its dwell: state <= GAP (or IDLE if GAP=0).
  - Total SHOW duration is exactly WIDTH*DWELL cycles.
- GAP: led=0 for GAP cycles. Then state <= IDLE, busy <= 0, and done=1 for exactly one cycle.
- start while busy=1 is ignored and not queued. start asserted in the same cycle done pulses (busy=0 in IDLE) is accepted.
- data_in and negate changes after capture have no effect on the frame in progress.
- Negation wraps: negate of 0 = 0, ovf=0. Negate of the most-negative value = itself, ovf=1.
- The first led bit appears 1 cycle after the start edge. done pulses at cycle 1 + WIDTH*DWELL + GAP relative to the start edge.

Optional Feature:
LED_BIT_SERIALIZER_MSB_FIRST_EN
- Defined: bits are displayed MSB first; bit_idx counts WIDTH-1 down to 0.
- Undefined: LSB first; bit_idx counts 0 up to WIDTH-1.
- Timing, handshake and ovf behaviour are identical in both builds.

Decomposition:
- Shared package led_show_pkg:
  - state encoding (IDLE, SHOW, GAP)
  - $clog2 width helper constants for counter widths
  - default DWELL/GAP constants for the 10 kHz clock
- One sub-module, negate_n:
  - parametrised WIDTH combinational two's complement
  - outputs the negated value plus an ovf flag
  - reused by the 32-bit negate path

Test Plan:
- WIDTH=8, DWELL=4, GAP=3; start with data_in=8'h35, negate=0 -> led sequence 1,0,1,0,1,1,0,0, each held 4 cycles. busy high for 35 cycles. done pulses once at cycle 36.
- Same config; data_in=8'h35, negate=1 -> displayed word 8'hCB, LSB-first sequence 1,1,0,1,0,0,1,1. ovf=0.
- data_in=8'h80, negate=1 -> displayed 8'h80, ovf=1. Then data_in=8'h00, negate=1 -> displayed 8'h00, ovf cleared to 0.
- Pulse start at cycle 10 of a running frame -> ignored: frame length unchanged, single done. Assert start in the done cycle -> new frame begins next cycle.
- Assert rst for one cycle mid-SHOW at bit 3 -> next cycle led=0, busy=0, bit_idx=0, no done pulse. A subsequent start behaves normally.
- Build with LED_BIT_SERIALIZER_MSB_FIRST_EN, data_in=8'h35 -> led sequence 0,0,1,1,0,1,0,1; bit_idx 7 down to 0.
